// File: rtl/mb32_arb.sv
// mb32_arb: round-robin front end sharing one pipelined multiplier
// among four requesters, with one result slot per requester.
module mb32_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int LAT   = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_mx,
    input  logic [NREQ*WIDTH-1:0]     req_my,
    output logic [NREQ-1:0]           res_valid,
    input  logic [NREQ-1:0]           res_ready,
    output logic [NREQ*2*WIDTH-1:0]   res_product,
    output logic [WIDTH-1:0]          mul_mx,
    output logic [WIDTH-1:0]          mul_my,
    input  logic [2*WIDTH-1:0]        mul_product,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] slot_occ;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   idx;
    logic            found;
    logic [LAT:0]    tag_v;
    logic [IW-1:0]   tag_id [LAT+1];

    assign elig = req_valid & ~slot_occ;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + IW'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign gnt       = found ? (NREQ'(1) << gidx) : '0;
    assign req_ready = gnt & {NREQ{RST}};
    assign busy      = |slot_occ;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            slot_occ    <= '0;
            rr_ptr      <= '0;
            mul_mx      <= '0;
            mul_my      <= '0;
            tag_v       <= '0;
            res_valid   <= '0;
            res_product <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            mul_mx    <= found ? req_mx[gidx*WIDTH +: WIDTH] : '0;
            mul_my    <= found ? req_my[gidx*WIDTH +: WIDTH] : '0;
            tag_v     <= {tag_v[LAT-1:0], found};
            tag_id[0] <= gidx;
            for (int k = 1; k <= LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            if (found) begin
                slot_occ[gidx] <= 1'b1;
                rr_ptr         <= gidx + IW'(1);
            end
            // An occupied slot is never eligible, so grant and release never collide
            for (int i = 0; i < NREQ; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    res_valid[i] <= 1'b0;
                    slot_occ[i]  <= 1'b0;
                end
            end
            if (tag_v[LAT]) begin
                res_valid[tag_id[LAT]] <= 1'b1;
                res_product[tag_id[LAT]*2*WIDTH +: 2*WIDTH] <= mul_product;
            end
        end
    end

endmodule

// File: tb/tb_mb32_arb.sv
// tb_mb32_arb: randomized and directed stimulus against a cycle-level
// round-robin reference model with a per-requester result scoreboard.
module tb_mb32_arb;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 2;

    typedef struct {
        logic [63:0] p;
        int          due;
    } exp_t;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_mx;
    logic [N*W-1:0]  req_my;
    logic [N-1:0]    res_valid;
    logic [N-1:0]    res_ready;
    logic [N*2*W-1:0] res_product;
    logic [W-1:0]    mul_mx;
    logic [W-1:0]    mul_my;
    logic [2*W-1:0]  mul_product;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [N-1:0] pend;
    logic [N-1:0] acc;
    exp_t q [N][$];
    logic [63:0] mpipe [LAT];

    mb32_arb #(.WIDTH(W), .NREQ(N), .LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mx(req_mx), .req_my(req_my),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product),
        .mul_mx(mul_mx), .mul_my(mul_my),
        .mul_product(mul_product), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Free-running external multiplier with LAT register stages
    always @(posedge CLK) begin
        mpipe[0] <= {32'b0, mul_mx} * {32'b0, mul_my};
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_product = mpipe[LAT-1];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Reference model: slot occupancy, rotating pointer, issue timing
    initial begin
        int rr;
        int g;
        logic [N-1:0] occ;
        logic [N-1:0] el;
        int due [N];
        logic [31:0] emx, emy, a, b;
        exp_t e;
        rr = 0; occ = '0; emx = '0; emy = '0;
        for (int i = 0; i < N; i++) due[i] = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk("rst_req_ready", 64'(req_ready), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_mul_mx", 64'(mul_mx), 64'd0);
                chk("rst_mul_my", 64'(mul_my), 64'd0);
                rr = 0; occ = '0; emx = '0; emy = '0;
            end else begin
                chk("mul_mx", 64'(mul_mx), 64'(emx));
                chk("mul_my", 64'(mul_my), 64'(emy));
                chk("busy", 64'(busy), 64'(|occ));
                el = req_valid & ~occ;
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && el[(rr + k) % N]) g = (rr + k) % N;
                chk("req_ready", 64'(req_ready),
                    (g >= 0) ? (64'd1 << g) : 64'd0);
                for (int i = 0; i < N; i++)
                    if (occ[i] && cyc >= due[i] && res_ready[i]) occ[i] = 1'b0;
                if (g >= 0) begin
                    a = req_mx[g*W +: W];
                    b = req_my[g*W +: W];
                    occ[g] = 1'b1;
                    due[g] = cyc + LAT + 2;
                    rr = (g + 1) % N;
                    emx = a; emy = b;
                    e.p = {32'b0, a} * {32'b0, b};
                    e.due = due[g];
                    q[g].push_back(e);
                end else begin
                    emx = '0; emy = '0;
                end
            end
        end
    end

    // Result monitor: pops expectations as results are presented
    initial begin
        logic ev;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                chk("rst_res_valid", 64'(res_valid), 64'd0);
                chk("rst_res_product", 64'(|res_product), 64'd0);
                for (int i = 0; i < N; i++) q[i].delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    ev = q[i].size() > 0 && cyc >= q[i][0].due;
                    chk($sformatf("res_valid[%0d]", i), 64'(res_valid[i]), 64'(ev));
                    if (ev && res_valid[i]) begin
                        chk($sformatf("res_product[%0d]", i),
                            res_product[i*64 +: 64], q[i][0].p);
                        if (res_ready[i]) void'(q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        acc = req_ready & req_valid;
        @(posedge CLK);
        #1;
        pend = pend & ~acc;
        req_valid = pend;
    endtask

    task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
        req_mx[i*W +: W] = a;
        req_my[i*W +: W] = b;
        pend[i] = 1'b1;
        req_valid[i] = 1'b1;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        res_ready = 4'hF;
        for (int n = 0; n < 400 && !done; n++) begin
            if (pend == 0 && busy == 1'b0) done = 1'b1;
            else step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%b pend=%b expected idle", busy, pend);
        end
    endtask

    initial begin
        int ng;
        bit got;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        bit got;
        RST = 1'b0;
        req_valid = '0; req_mx = '0; req_my = '0;
        res_ready = 4'hF; pend = '0; acc = '0;
        repeat (3) step();

        // Contention straight out of reset
        post(0, 32'h11, 32'h2);
        post(1, 32'h22, 32'h3);
        post(2, 32'h33, 32'h4);
        post(3, 32'h44, 32'h5);
        @(posedge CLK); #1;
        RST = 1'b1;
        wait_idle();

        // Single issue on requester 1
        post(1, 32'h3, 32'h5);
        wait_idle();

        // Operand extremes
        post(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        post(3, 32'h0, 32'hFFFF_FFFF);
        wait_idle();

        // Backpressure on requester 2 while others keep running
        res_ready = 4'b1011;
        post(2, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int n = 0; n < 14; n++) begin
            step();
            for (int i = 0; i < N; i++)
                if (!pend[i]) post(i, rnd(), rnd());
        end
        wait_idle();

        // Fairness: requester 0 always valid, requester 2 asks once
        for (int n = 0; n < 6; n++) begin
            if (!pend[0]) post(0, rnd(), rnd());
            step();
        end
        if (!pend[0]) post(0, rnd(), rnd());
        post(2, 32'h7, 32'h9);
        ng = 0; got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (acc != 0) ng++;
            if (acc[2]) got = 1'b1;
            if (!pend[0]) post(0, rnd(), rnd());
        end
        chk("fair_granted", 64'(got), 64'd1);
        chk("fair_within_2", 64'(ng <= 2), 64'd1);
        wait_idle();

        // Random traffic with random result backpressure
        for (int n = 0; n < 400; n++) begin
            step();
            res_ready = 4'($urandom);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) post(i, rnd(), rnd());
        end
        wait_idle();

        // Reset one cycle after granting requester 3
        post(3, 32'hDEAD_BEEF, 32'h1000);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            if (acc[3]) got = 1'b1;
        end
        chk("rst3_granted", 64'(got), 64'd1);
        #2 RST = 1'b0;
        #1;
        chk("async_req_ready", 64'(req_ready), 64'd0);
        chk("async_res_valid", 64'(res_valid), 64'd0);
        chk("async_mul_mx", 64'(mul_mx), 64'd0);
        chk("async_mul_my", 64'(mul_my), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        pend = '0; req_valid = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (10) step();
        chk("post_rst_busy", 64'(busy), 64'd0);
        post(2, 32'h6, 32'h7);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mb32_arb.md
MB32_ARB -- requirements
Module: mb32_arb

Interface
REQ-001 Parameter WIDTH, default 32: operand width; product width is 2*WIDTH.
REQ-002 Parameter NREQ, default 4: number of requesters; fixed at 4 for this release.
REQ-003 Parameter LAT, default 2: cycles from operands on mul_mx/mul_my to a valid mul_product; legal range 1-8.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operand request.
REQ-007 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-008 req_mx  in  NREQ*WIDTH  multiplicands; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_my  in  NREQ*WIDTH  multipliers; same packing as req_mx.
REQ-010 res_valid  out  NREQ  per-requester result available.
REQ-011 res_ready  in  NREQ  per-requester result accept.
REQ-012 res_product  out  NREQ*2*WIDTH  per-requester result; requester i at bits [i*2*WIDTH +: 2*WIDTH].
REQ-013 mul_mx, mul_my  out  WIDTH each  registered operands to the shared multiplier.
REQ-014 mul_product  in  2*WIDTH  multiplier output.
REQ-015 busy  out  1  high while any requester slot is occupied.

Function
REQ-016 The block SHALL share one free-running pipelined multiplier among NREQ requesters, issuing at most one operation per cycle.
REQ-017 Each requester SHALL own one slot; a slot becomes occupied at request handshake and is freed at result handshake (res_valid & res_ready).
REQ-018 Eligible set SHALL be req_valid & ~slot_occupied.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr, then rr_ptr+1 mod NREQ, and so on; the first eligible requester is granted.
REQ-020 req_ready[g] SHALL be asserted combinationally in the grant cycle only for the granted requester g; req_ready is zero when the eligible set is empty.
REQ-021 On grant, rr_ptr SHALL update to (g+1) mod NREQ; with no grant, rr_ptr holds.
REQ-022 When a grant occurs in cycle t, mul_mx/mul_my SHALL carry that requester's operands during cycle t+1; otherwise both are driven to zero in t+1.
REQ-023 A tag pipeline (valid bit + 2-bit requester ID) SHALL track each issue; mul_product is captured into slot g's result register at the end of cycle t+1+LAT.
REQ-024 res_valid[g] SHALL rise in cycle t+2+LAT (LAT=2: grant t, result t+4) and hold with res_product stable until res_ready[g] is sampled high.
REQ-025 A freed slot SHALL be eligible in the cycle after its result handshake; handshake and re-request are never accepted in the same cycle.
REQ-026 Results for different requesters SHALL complete in issue order; independent res_ready per requester means no result blocks another.
REQ-027 A non-granted requester with req_valid high SHALL retain its request; the block never drops or reorders operands within a requester.
REQ-028 All four requesters continuously valid with res_ready high SHALL receive grants in strict rotation; no requester waits more than NREQ grant cycles.
REQ-029 busy SHALL equal OR of slot_occupied.
REQ-030 Products SHALL be unsigned 2*WIDTH-bit, passed through unmodified; the block performs no arithmetic on data.

Reset
REQ-031 RST low SHALL asynchronously clear: slots, tag pipeline, result registers, res_valid, req_ready-driving state, mul_mx, mul_my, busy to 0; rr_ptr to 0.
REQ-032 Reset mid-operation SHALL discard all in-flight and held results; no res_valid asserts for pre-reset issues after RST deasserts.
REQ-033 After RST deassertion, the first grant SHALL be possible on the first rising edge with RST high.

Verification
REQ-034 Single issue, LAT=2: requester 1 sends mx=0x0000_0003, my=0x0000_0005 at cycle t -> req_ready[1]=1 in t, mul_mx=3/mul_my=5 in t+1, res_valid[1]=1 with product 0x0F in t+4.
REQ-035 Contention: all four valid from reset with distinct operands, res_ready=4'hF -> grants in order 0,1,2,3 on consecutive cycles; results return in order 0,1,2,3 on cycles t+4..t+7.
REQ-036 Backpressure: requester 2 result held with res_ready[2]=0 for 10 cycles while req_valid[2]=1 -> req_ready[2] stays 0, res_product stable, others keep being served; first re-grant of 2 one cycle after res_ready[2] handshake.
REQ-037 Extremes: mx=my=0xFFFF_FFFF -> product 0xFFFF_FFFE_0000_0001; mx=0, my=0xFFFF_FFFF -> product 0.
REQ-038 Reset mid-flight: RST low one cycle after grant to requester 3 -> all outputs 0 immediately; after release no res_valid appears without a new request.
REQ-039 Fairness: requester 0 always valid, requester 2 asserts once -> requester 2 granted within 2 grant cycles of asserting.
